// File: rtl/csr_pkg.sv
// CSR index map, operation/state encodings and the Zicsr read-modify-write rule.
// Shared by the trap/CSR access sequencer.
package csr_pkg;

    localparam int CSR_XLEN = 64;

    localparam logic [1:0] CSR_MEPC   = 2'd0;
    localparam logic [1:0] CSR_MCAUSE = 2'd1;
    localparam logic [1:0] CSR_MTVEC  = 2'd2;
    localparam logic [1:0] CSR_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAP_EPC,
        ST_TRAP_CAUSE,
        ST_TRAP_VEC,
        ST_MRET_RD,
        ST_CSR_RMW,
        ST_RESP
    } ctrl_state_e;

    // Illegal op degenerates to a read: the new value equals the old one.
    function automatic logic [CSR_XLEN-1:0] csr_rmw(
        input csr_op_e             op,
        input logic [CSR_XLEN-1:0] old_val,
        input logic [CSR_XLEN-1:0] src
    );
        case (op)
            CSR_OP_RW: return src;
            CSR_OP_RS: return old_val | src;
            CSR_OP_RC: return old_val & ~src;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap entry / mret / Zicsr RMW sequencer driving the machine CSR file; optional trap counter under CSR_TRAP_CNT_EN.
// Latency: trap done at T+4, mret and CSR ops done at T+2 after accept at T.
// Backpressure: o_ready only in IDLE; requests must be held until accepted, requests while busy are ignored.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_trap_req,
    input  logic [DATA_WIDTH-1:0] i_trap_pc,
    input  logic [DATA_WIDTH-1:0] i_trap_cause,
    input  logic                  i_mret_req,
    input  logic                  i_csr_req,
    input  logic [1:0]            i_csr_op,
    input  logic [ADDR_WIDTH-1:0] i_csr_addr,
    input  logic [DATA_WIDTH-1:0] i_csr_src,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic [DATA_WIDTH-1:0] o_csr_rd_data,
    output logic                  o_csr_illegal,
    output logic                  o_csr_we,
    output logic [ADDR_WIDTH-1:0] o_csr_waddr,
    output logic [DATA_WIDTH-1:0] o_csr_wdata,
    output logic [ADDR_WIDTH-1:0] o_csr_raddr,
    input  logic [DATA_WIDTH-1:0] i_csr_rdata
`ifdef CSR_TRAP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_trap_count
`endif
);

    ctrl_state_e           state_q;
    logic [DATA_WIDTH-1:0] pc_q, cause_q, src_q;
    csr_op_e               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q, rd_data_q;
    logic                  done_q, redir_vld_q, illegal_q;

    logic                  rsvd_sel_d, rmw_wr_d;
    logic [DATA_WIDTH-1:0] rmw_old_d, rmw_new_d;

    assign rsvd_sel_d = (addr_q == ADDR_WIDTH'(CSR_RSVD));
    // Set/clear with a zero mask must not touch the file (no side effect).
    assign rmw_wr_d   = !rsvd_sel_d &&
                        ((op_q == CSR_OP_RW) ||
                         (((op_q == CSR_OP_RS) || (op_q == CSR_OP_RC)) && (src_q != '0)));
    assign rmw_old_d  = rsvd_sel_d ? '0 : i_csr_rdata;
    assign rmw_new_d  = DATA_WIDTH'(csr_rmw(op_q, CSR_XLEN'(i_csr_rdata), CSR_XLEN'(src_q)));

    always_comb begin
        o_csr_we    = 1'b0;
        o_csr_waddr = '0;
        o_csr_wdata = '0;
        o_csr_raddr = '0;
        case (state_q)
            ST_TRAP_EPC: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = ADDR_WIDTH'(CSR_MEPC);
                o_csr_wdata = pc_q;
            end
            ST_TRAP_CAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = ADDR_WIDTH'(CSR_MCAUSE);
                o_csr_wdata = cause_q;
            end
            ST_TRAP_VEC: o_csr_raddr = ADDR_WIDTH'(CSR_MTVEC);
            ST_MRET_RD:  o_csr_raddr = ADDR_WIDTH'(CSR_MEPC);
            ST_CSR_RMW: begin
                o_csr_raddr = addr_q;
                o_csr_we    = rmw_wr_d;
                o_csr_waddr = rmw_wr_d ? addr_q : '0;
                o_csr_wdata = rmw_wr_d ? rmw_new_d : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            cause_q       <= '0;
            src_q         <= '0;
            op_q          <= CSR_OP_ILL;
            addr_q        <= '0;
            redirect_pc_q <= '0;
            rd_data_q     <= '0;
            done_q        <= 1'b0;
            redir_vld_q   <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            redir_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_trap_req) begin
                        pc_q    <= i_trap_pc;
                        cause_q <= i_trap_cause;
                        state_q <= ST_TRAP_EPC;
                    end else if (i_mret_req) begin
                        state_q <= ST_MRET_RD;
                    end else if (i_csr_req) begin
                        op_q    <= csr_op_e'(i_csr_op);
                        addr_q  <= i_csr_addr;
                        src_q   <= i_csr_src;
                        state_q <= ST_CSR_RMW;
                    end
                end
                ST_TRAP_EPC:   state_q <= ST_TRAP_CAUSE;
                ST_TRAP_CAUSE: state_q <= ST_TRAP_VEC;
                ST_TRAP_VEC: begin
                    redirect_pc_q <= {i_csr_rdata[DATA_WIDTH-1:2], 2'b00};
                    done_q        <= 1'b1;
                    redir_vld_q   <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_MRET_RD: begin
                    redirect_pc_q <= i_csr_rdata;
                    done_q        <= 1'b1;
                    redir_vld_q   <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_CSR_RMW: begin
                    rd_data_q <= rmw_old_d;
                    illegal_q <= rsvd_sel_d;
                    done_q    <= 1'b1;
                    state_q   <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CSR_TRAP_CNT_EN
    logic [CNT_WIDTH-1:0] trap_cnt_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            trap_cnt_q <= '0;
        end else if ((state_q == ST_TRAP_VEC) && (trap_cnt_q != '1)) begin
            trap_cnt_q <= trap_cnt_q + 1'b1;
        end
    end

    assign o_trap_count = trap_cnt_q;
`endif

    assign o_ready          = (state_q == ST_IDLE);
    assign o_done           = done_q;
    assign o_redirect_valid = redir_vld_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_csr_rd_data    = rd_data_q;
    assign o_csr_illegal    = illegal_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed scenarios plus random trap/mret/CSR traffic against a CSR-file model.
// Optional CSR_TRAP_CNT_EN section checks the saturating trap counter with a 2-bit width.
module tb_csr_trap_ctrl;

    logic        clk, arstn;
    logic        i_trap_req, i_mret_req, i_csr_req;
    logic [63:0] i_trap_pc, i_trap_cause, i_csr_src, i_csr_rdata;
    logic [1:0]  i_csr_op, i_csr_addr;
    logic        o_ready, o_done, o_redirect_valid, o_csr_illegal, o_csr_we;
    logic [63:0] o_redirect_pc, o_csr_rd_data, o_csr_wdata;
    logic [1:0]  o_csr_waddr, o_csr_raddr;
`ifdef CSR_TRAP_CNT_EN
    logic [1:0]  o_trap_count;
`endif

    csr_trap_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(2), .CNT_WIDTH(2)) dut (
        .clk(clk), .arstn(arstn),
        .i_trap_req(i_trap_req), .i_trap_pc(i_trap_pc), .i_trap_cause(i_trap_cause),
        .i_mret_req(i_mret_req), .i_csr_req(i_csr_req), .i_csr_op(i_csr_op),
        .i_csr_addr(i_csr_addr), .i_csr_src(i_csr_src),
        .o_ready(o_ready), .o_done(o_done), .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc(o_redirect_pc), .o_csr_rd_data(o_csr_rd_data),
        .o_csr_illegal(o_csr_illegal), .o_csr_we(o_csr_we), .o_csr_waddr(o_csr_waddr),
        .o_csr_wdata(o_csr_wdata), .o_csr_raddr(o_csr_raddr), .i_csr_rdata(i_csr_rdata)
`ifdef CSR_TRAP_CNT_EN
        , .o_trap_count(o_trap_count)
`endif
    );

    // CSR file seen by the DUT; entry 3 holds junk that must never reach rd.
    logic [63:0] tb_mem [4] = '{64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D};
    assign i_csr_rdata = tb_mem[o_csr_raddr];
    always @(posedge clk) if (o_csr_we) tb_mem[o_csr_waddr] <= o_csr_wdata;

    typedef struct {int c; logic [1:0] a; logic [63:0] d;} wr_t;
    wr_t wlog[$];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_csr_we) wlog.push_back('{cyc, o_csr_waddr, o_csr_wdata});

    int          checks = 0, errors = 0;
    logic [63:0] ref_mem [3];
    int          tcnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 trap, 1 mret, 2 CSR op. Called and returns at a negedge with the DUT idle.
    task automatic run_op(input int kind, input logic [63:0] pc, input logic [63:0] cause,
                          input logic [1:0] op, input logic [1:0] addr, input logic [63:0] src,
                          input string tag);
        int          acc, lat, n;
        logic [63:0] old_v, new_v, exp_red;
        bit          do_wr;
        wr_t         exp_q[$];
        acc = cyc;
        lat = (kind == 0) ? 4 : 2;
        exp_red = '0; old_v = '0; new_v = '0; do_wr = 0;
        if (kind == 0) begin
            exp_red = ref_mem[2] & ~64'h3;
            exp_q.push_back('{acc + 1, 2'd0, pc});
            exp_q.push_back('{acc + 2, 2'd1, cause});
        end else if (kind == 1) begin
            exp_red = ref_mem[0];
        end else begin
            old_v = (addr == 2'd3) ? 64'h0 : ref_mem[addr];
            case (op)
                2'd1:    new_v = src;
                2'd2:    new_v = old_v | src;
                2'd3:    new_v = old_v & ~src;
                default: new_v = old_v;
            endcase
            do_wr = (addr != 2'd3) && ((op == 2'd1) || (op != 2'd0 && src != 64'h0));
            if (do_wr) exp_q.push_back('{acc + 1, addr, new_v});
        end
        wlog.delete();
        if (kind == 0) begin
            i_trap_pc = pc; i_trap_cause = cause; i_trap_req = 1'b1;
        end else if (kind == 1) begin
            i_mret_req = 1'b1;
        end else begin
            i_csr_op = op; i_csr_addr = addr; i_csr_src = src; i_csr_req = 1'b1;
        end
        chk({tag, "/ready_idle"}, o_ready, 1);
        @(posedge clk); @(negedge clk);
        if (kind == 0) i_trap_req = 1'b0;
        else if (kind == 1) i_mret_req = 1'b0;
        else i_csr_req = 1'b0;
        chk({tag, "/ready_busy"}, o_ready, 0);
        n = 1;
        while (o_done !== 1'b1 && n < 10) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk({tag, "/latency"}, n, lat);
        chk({tag, "/redirect_valid"}, o_redirect_valid, (kind != 2));
        if (kind != 2) begin
            chk({tag, "/redirect_pc"}, o_redirect_pc, exp_red);
        end else begin
            chk({tag, "/rd_data"}, o_csr_rd_data, old_v);
            chk({tag, "/illegal"}, o_csr_illegal, (addr == 2'd3));
        end
        chk({tag, "/num_writes"}, wlog.size(), exp_q.size());
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++) begin
            chk({tag, "/wr_cycle"}, wlog[i].c - acc, exp_q[i].c - acc);
            chk({tag, "/wr_addr"}, wlog[i].a, exp_q[i].a);
            chk({tag, "/wr_data"}, wlog[i].d, exp_q[i].d);
        end
        if (kind == 0) begin
            ref_mem[0] = pc; ref_mem[1] = cause;
            if (tcnt < 3) tcnt++;
        end else if (kind == 2 && do_wr) begin
            ref_mem[addr] = new_v;
        end
        @(posedge clk); @(negedge clk);
        chk({tag, "/done_one_cycle"}, o_done, 0);
        chk({tag, "/ready_after"}, o_ready, 1);
        if (kind != 2) chk({tag, "/redirect_hold"}, o_redirect_pc, exp_red);
        for (int i = 0; i < 3; i++) chk({tag, "/csr_file"}, tb_mem[i], ref_mem[i]);
`ifdef CSR_TRAP_CNT_EN
        chk({tag, "/trap_count"}, o_trap_count, tcnt);
`endif
    endtask

    initial begin
        logic [63:0] rpc, rcause, rsrc;
        arstn = 1'b0;
        i_trap_req = 0; i_mret_req = 0; i_csr_req = 0;
        i_trap_pc = '0; i_trap_cause = '0; i_csr_src = '0; i_csr_op = '0; i_csr_addr = '0;
        for (int i = 0; i < 3; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst/ready", o_ready, 1);
        chk("rst/done", o_done, 0);
        chk("rst/redirect_valid", o_redirect_valid, 0);
        chk("rst/illegal", o_csr_illegal, 0);
        chk("rst/we", o_csr_we, 0);
        chk("rst/redirect_pc", o_redirect_pc, 0);
        chk("rst/rd_data", o_csr_rd_data, 0);
        chk("rst/raddr", o_csr_raddr, 0);
        arstn = 1'b1;
        @(negedge clk);

        run_op(2, 0, 0, 2'd1, 2'd2, 64'h100, "csrrw_mtvec");
        run_op(0, 64'h8000_0010, 64'hB, 0, 0, 0, "trap_basic");
        run_op(2, 0, 0, 2'd2, 2'd1, 64'h0, "csrrs_zero");
        run_op(2, 0, 0, 2'd3, 2'd1, 64'h3, "csrrc_mcause");
        run_op(2, 0, 0, 2'd1, 2'd2, 64'h203, "csrrw_mtvec_odd");
        run_op(0, 64'h4000_0024, 64'h2, 0, 0, 0, "trap_masked");
        run_op(1, 0, 0, 0, 0, 0, "mret");

        // All three requests in one cycle: loser requests stay asserted.
        i_mret_req = 1'b1;
        i_csr_op = 2'd1; i_csr_addr = 2'd1; i_csr_src = 64'h77; i_csr_req = 1'b1;
        run_op(0, 64'h9000_0100, 64'h7, 0, 0, 0, "prio_trap");
        run_op(1, 0, 0, 0, 0, 0, "prio_mret");
        run_op(2, 0, 0, 2'd1, 2'd1, 64'h77, "prio_csr");

        run_op(2, 0, 0, 2'd1, 2'd3, 64'h55, "csrrw_rsvd");
        run_op(2, 0, 0, 2'd0, 2'd0, 64'hFFFF, "csr_op00");

        // Reset while in TRAP_CAUSE: mepc already written, mcause must not be.
        wlog.delete();
        i_trap_pc = 64'hA000_0000; i_trap_cause = 64'h3; i_trap_req = 1'b1;
        @(posedge clk); @(negedge clk);
        i_trap_req = 1'b0;
        @(posedge clk);
        #1 arstn = 1'b0;
        #1;
        chk("midrst/ready", o_ready, 1);
        chk("midrst/we", o_csr_we, 0);
        @(negedge clk);
        arstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk("midrst/no_done", o_done, 0);
        end
        chk("midrst/num_writes", wlog.size(), 1);
        ref_mem[0] = 64'hA000_0000;
        tcnt = 0;
        for (int i = 0; i < 3; i++) chk("midrst/csr_file", tb_mem[i], ref_mem[i]);
        chk("midrst/redirect_pc", o_redirect_pc, 0);

        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(0, 2);
            rpc = {$urandom, $urandom};
            rcause = {$urandom, $urandom};
            rsrc = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            run_op(k, rpc, rcause, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rsrc, "rand");
        end

`ifdef CSR_TRAP_CNT_EN
        arstn = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        tcnt = 0;
        @(negedge clk);
        chk("cnt/reset", o_trap_count, 0);
        for (int i = 0; i < 5; i++) run_op(0, 64'h1000 + 64'(i), 64'h1, 0, 0, 0, "cnt_trap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
